// File: rtl/store_wb_buffer.sv
// store_wb_buffer: receiving end of the store-queue retire interface.
// Up to three retired stores per cycle are compacted into an in-order FIFO.
// They are then written one at a time to the D-cache/data-memory write port
// using a req/ack handshake.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-low reset
//   retire_valid[2:0]    slot valids, bit 2 = oldest store
//   retire_store[2:0]    SQ packets (addr, data, usebytes)
//   retire_stall[2:0]    per-slot back-pressure, derived from registered count
//   mem_req/addr/data/be head-entry write request, held stable until mem_ack
//   mem_ack              write accepted this cycle
//   halt_drain           drain request before halt (informational)
//   drained              FIFO empty and no request outstanding
//   overflow             sticky: a retire packet exceeded the free space
//
// Optional feature macro STORE_WB_FWD_EN adds the store-to-load forwarding
// lookup ports ld_addr / fwd_hit / fwd_data / fwd_be.

package store_wb_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  usebytes;
  } SQ_ENTRY_PACKET;
endpackage

module store_wb_buffer #(
  parameter int WB_DEPTH = 8,
  parameter int WB_IDX   = 3
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [2:0]                        retire_valid,
  input  store_wb_pkg::SQ_ENTRY_PACKET [2:0] retire_store,
  output logic [2:0]                        retire_stall,
  output logic                              mem_req,
  output logic [31:0]                       mem_addr,
  output logic [31:0]                       mem_data,
  output logic [3:0]                        mem_be,
  input  logic                              mem_ack,
  input  logic                              halt_drain,
  output logic                              drained,
`ifdef STORE_WB_FWD_EN
  input  logic [31:0]                       ld_addr,
  output logic                              fwd_hit,
  output logic [31:0]                       fwd_data,
  output logic [3:0]                        fwd_be,
`endif
  output logic                              overflow
);

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  be;
  } wb_entry_t;

  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [WB_IDX:0] DEPTH_C = (WB_IDX+1)'(WB_DEPTH);

  wb_entry_t            entries_q [WB_DEPTH];
  wb_entry_t            entries_d [WB_DEPTH];
  logic [WB_IDX-1:0]    head_q, head_d;
  logic [WB_IDX-1:0]    tail_q, tail_d;
  logic [WB_IDX:0]      count_q, count_d;
  logic                 overflow_q, overflow_d;
  state_t               state_q, state_d;

  logic [WB_IDX:0]      free;
  logic [1:0]           n_push;
  logic [1:0]           n_acc;
  logic [1:0]           wr_cnt;
  logic                 over;
  logic                 pop;
  logic [WB_IDX-1:0]    wr_ptr;

  // Low address bits are not stored (writes are word-aligned); halt_drain has
  // no effect on the datapath in this build.
  logic unused_ok;
  assign unused_ok = ^{halt_drain, retire_store[2].addr[1:0],
                       retire_store[1].addr[1:0], retire_store[0].addr[1:0]};

  // Stall depends only on registered occupancy so retire never sees a
  // combinational path from mem_ack or retire_valid.
  always_comb begin
    free = DEPTH_C - count_q;
    if (free == '0)
      retire_stall = 3'b111;
    else if (free == (WB_IDX+1)'(1))
      retire_stall = 3'b011;
    else if (free == (WB_IDX+1)'(2))
      retire_stall = 3'b001;
    else
      retire_stall = 3'b000;
  end

  // Push/pop bookkeeping. A packet larger than the free space keeps its
  // oldest stores and drops the rest, raising the sticky overflow flag.
  always_comb begin
    n_push     = {1'b0, retire_valid[2]} + {1'b0, retire_valid[1]} + {1'b0, retire_valid[0]};
    over       = ((WB_IDX+1)'(n_push) > free);
    n_acc      = over ? free[1:0] : n_push;
    pop        = (state_q == REQ) && mem_ack;
    entries_d  = entries_q;
    head_d     = head_q;
    overflow_d = overflow_q | over;
    wr_cnt     = 2'd0;
    wr_ptr     = tail_q;

    if (pop) begin
      entries_d[head_q] = '0;
      head_d            = head_q + WB_IDX'(1);
    end

    // Compact valid slots (oldest first) onto consecutive tail positions.
    for (int s = 2; s >= 0; s--) begin
      if (retire_valid[s] && (wr_cnt < n_acc)) begin
        wr_ptr            = tail_q + WB_IDX'(wr_cnt);
        entries_d[wr_ptr] = '{waddr: retire_store[s].addr[31:2],
                              data:  retire_store[s].data,
                              be:    retire_store[s].usebytes};
        wr_cnt            = wr_cnt + 2'd1;
      end
    end

    tail_d  = tail_q + WB_IDX'(n_acc);
    count_d = count_q + (WB_IDX+1)'(n_acc) - (WB_IDX+1)'(pop);
  end

  // Request FSM: the head entry is presented directly, so it remains
  // stable until the ack pops it.
  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    mem_be   = '0;
    case (state_q)
      IDLE: begin
        if (count_q != '0)
          state_d = REQ;
      end
      REQ: begin
        mem_req  = 1'b1;
        mem_addr = {entries_q[head_q].waddr, 2'b00};
        mem_data = entries_q[head_q].data;
        mem_be   = entries_q[head_q].be;
        if (mem_ack)
          state_d = (count_d != '0) ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < WB_DEPTH; i++)
        entries_q[i] <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < WB_DEPTH; i++)
        entries_q[i] <= entries_d[i];
    end
  end

  assign drained  = (count_q == '0) && (state_q == IDLE);
  assign overflow = overflow_q;

`ifdef STORE_WB_FWD_EN
  logic [WB_IDX-1:0] fwd_ptr;
  logic              unused_fwd;
  assign unused_fwd = ^ld_addr[1:0];

  // Walk from oldest to youngest so the youngest matching store wins.
  // Only registered entries are searched.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_be   = '0;
    fwd_ptr  = head_q;
    for (int i = 0; i < WB_DEPTH; i++) begin
      fwd_ptr = head_q + WB_IDX'(i);
      if (((WB_IDX+1)'(i) < count_q) && (entries_q[fwd_ptr].waddr == ld_addr[31:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = entries_q[fwd_ptr].data;
        fwd_be   = entries_q[fwd_ptr].be;
      end
    end
  end
`endif

endmodule

// File: tb/tb_store_wb_buffer.sv
module tb_store_wb_buffer;
  import store_wb_pkg::*;

  logic                     clock;
  logic                     reset;
  logic [2:0]               retire_valid;
  SQ_ENTRY_PACKET [2:0]     retire_store;
  logic [2:0]               retire_stall;
  logic                     mem_req;
  logic [31:0]              mem_addr;
  logic [31:0]              mem_data;
  logic [3:0]               mem_be;
  logic                     mem_ack;
  logic                     halt_drain;
  logic                     drained;
  logic                     overflow;
`ifdef STORE_WB_FWD_EN
  logic [31:0]              ld_addr;
  logic                     fwd_hit;
  logic [31:0]              fwd_data;
  logic [3:0]               fwd_be;
`endif

  int total = 0;
  int bad   = 0;

  logic [67:0] exp_q[$];
  logic [67:0] got_q[$];

  store_wb_buffer #(.WB_DEPTH(8), .WB_IDX(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .retire_valid (retire_valid),
    .retire_store (retire_store),
    .retire_stall (retire_stall),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_be       (mem_be),
    .mem_ack      (mem_ack),
    .halt_drain   (halt_drain),
    .drained      (drained),
`ifdef STORE_WB_FWD_EN
    .ld_addr      (ld_addr),
    .fwd_hit      (fwd_hit),
    .fwd_data     (fwd_data),
    .fwd_be       (fwd_be),
`endif
    .overflow     (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change 1 time unit after posedge, so the negedge view is exactly
  // what the next posedge will act on.
  always @(negedge clock) begin
    if (reset && mem_req && mem_ack)
      got_q.push_back({mem_addr, mem_data, mem_be});
  end

  task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic SQ_ENTRY_PACKET st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    SQ_ENTRY_PACKET p;
    p.addr = a; p.data = d; p.usebytes = b;
    return p;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one retire packet for one cycle; optionally record the stores
  // expected to reach memory (oldest slot first).
  task automatic push(input logic [2:0] v, input SQ_ENTRY_PACKET s2, input SQ_ENTRY_PACKET s1,
                      input SQ_ENTRY_PACKET s0, input bit rec);
    SQ_ENTRY_PACKET s [3];
    s[2] = s2; s[1] = s1; s[0] = s0;
    retire_valid = v;
    retire_store = {s2, s1, s0};
    if (rec)
      for (int i = 2; i >= 0; i--)
        if (v[i]) exp_q.push_back({s[i].addr & 32'hFFFF_FFFC, s[i].data, s[i].usebytes});
    tick();
    retire_valid = 3'b000;
    retire_store = '0;
  endtask

  task automatic drain(input string tag);
    mem_ack = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (drained) break;
    end
    chk({tag, "_drained"}, 68'(drained), 68'(1));
    chk({tag, "_nwrites"}, 68'(got_q.size()), 68'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), got_q[i], exp_q[i]);
    exp_q.delete();
    got_q.delete();
    tick();
    mem_ack = 1'b0;
  endtask

  SQ_ENTRY_PACKET z;
  logic [31:0] first_addr;

  initial begin
    z = '0;
    reset = 1'b0;
    retire_valid = 3'b000;
    retire_store = '0;
    mem_ack = 1'b0;
    halt_drain = 1'b0;
`ifdef STORE_WB_FWD_EN
    ld_addr = 32'h0;
`endif
    @(negedge clock);
    chk("rst_drained", 68'(drained), 68'(1));
    chk("rst_req", 68'(mem_req), 68'(0));
    chk("rst_stall", 68'(retire_stall), 68'(0));
    chk("rst_ovf", 68'(overflow), 68'(0));
    chk("rst_addr", 68'(mem_addr), 68'(0));
    tick();
    reset = 1'b1;
    tick();

    // Three stores in one packet, ack held high.
    mem_ack = 1'b1;
    push(3'b111, st(32'h100, 32'h11, 4'hF), st(32'h104, 32'h22, 4'h3), st(32'h108, 32'h33, 4'hC), 1);
    chk("t1_req_idle", 68'(mem_req), 68'(0));
    chk("t1_notdrained", 68'(drained), 68'(0));
    tick();
    chk("t1_req_up", 68'(mem_req), 68'(1));
    chk("t1_head", 68'(mem_addr), 68'(32'h100));
    drain("t1");

    // Fill with ack low: stall steps as count reaches 6, 7, 8.
    push(3'b111, st(32'h400, 32'h1000, 4'hF), st(32'h404, 32'h1001, 4'hF), st(32'h408, 32'h1002, 4'hF), 1);
    chk("t2_stall3", 68'(retire_stall), 68'(3'b000));
    push(3'b111, st(32'h40C, 32'h1003, 4'hF), st(32'h410, 32'h1004, 4'hF), st(32'h414, 32'h1005, 4'hF), 1);
    chk("t2_stall6", 68'(retire_stall), 68'(3'b001));
    chk("t2_addr6", 68'(mem_addr), 68'(32'h400));
    push(3'b100, st(32'h418, 32'h1006, 4'hF), z, z, 1);
    chk("t2_stall7", 68'(retire_stall), 68'(3'b011));
    chk("t2_addr7", 68'(mem_addr), 68'(32'h400));
    push(3'b100, st(32'h41C, 32'h1007, 4'hF), z, z, 1);
    chk("t2_stall8", 68'(retire_stall), 68'(3'b111));
    chk("t2_addr8", 68'(mem_addr), 68'(32'h400));
    chk("t2_data8", 68'(mem_data), 68'(32'h1000));
    drain("t2");

    // Non-contiguous packet with unaligned address and distinct byte enables.
    push(3'b101, st(32'h302, 32'hAAAA, 4'h5), st(32'h3F0, 32'hDEAD, 4'hF), st(32'h304, 32'hBBBB, 4'hA), 1);
    drain("t3");

    // Wrap-around: 6 in, 6 out, 5 in.
    push(3'b111, st(32'h500, 32'h50, 4'h1), st(32'h504, 32'h51, 4'h2), st(32'h508, 32'h52, 4'h4), 1);
    push(3'b111, st(32'h50C, 32'h53, 4'h8), st(32'h510, 32'h54, 4'h3), st(32'h514, 32'h55, 4'h6), 1);
    drain("t4a");
    push(3'b111, st(32'h600, 32'h60, 4'h9), st(32'h604, 32'h61, 4'hA), st(32'h608, 32'h62, 4'hB), 1);
    push(3'b011, z, st(32'h60C, 32'h63, 4'hC), st(32'h610, 32'h64, 4'hD), 1);
    drain("t4b");
    chk("t4_stall_empty", 68'(retire_stall), 68'(0));

    // Overflow: fill to 8, then force a 3-store packet.
    push(3'b111, st(32'h700, 32'h70, 4'hF), st(32'h704, 32'h71, 4'hF), st(32'h708, 32'h72, 4'hF), 1);
    push(3'b111, st(32'h70C, 32'h73, 4'hF), st(32'h710, 32'h74, 4'hF), st(32'h714, 32'h75, 4'hF), 1);
    push(3'b011, z, st(32'h718, 32'h76, 4'hF), st(32'h71C, 32'h77, 4'hF), 1);
    chk("t5_pre_ovf", 68'(overflow), 68'(0));
    push(3'b111, st(32'h7F0, 32'hE0, 4'hF), st(32'h7F4, 32'hE1, 4'hF), st(32'h7F8, 32'hE2, 4'hF), 0);
    chk("t5_ovf", 68'(overflow), 68'(1));
    chk("t5_stall_full", 68'(retire_stall), 68'(3'b111));
    tick();
    chk("t5_ovf_sticky", 68'(overflow), 68'(1));
    drain("t5");
    chk("t5_ovf_after", 68'(overflow), 68'(1));

    // Reset in the middle of a request with 4 entries queued.
    push(3'b111, st(32'h800, 32'h80, 4'hF), st(32'h804, 32'h81, 4'hF), st(32'h808, 32'h82, 4'hF), 0);
    push(3'b100, st(32'h80C, 32'h83, 4'hF), z, z, 0);
    chk("t6_req", 68'(mem_req), 68'(1));
    reset = 1'b0;
    #1;
    chk("t6_req_rst", 68'(mem_req), 68'(0));
    chk("t6_drained_rst", 68'(drained), 68'(1));
    chk("t6_ovf_rst", 68'(overflow), 68'(0));
    chk("t6_addr_rst", 68'(mem_addr), 68'(0));
    tick();
    reset = 1'b1;
    tick();
    first_addr = 32'h900;
    push(3'b001, z, z, st(first_addr, 32'h90, 4'h7), 1);
    drain("t6_post");

`ifdef STORE_WB_FWD_EN
    ld_addr = 32'h202;
    push(3'b110, st(32'h200, 32'h1, 4'h1), st(32'h200, 32'h2, 4'h3), z, 0);
    chk("fwd_hit", 68'(fwd_hit), 68'(1));
    chk("fwd_data", 68'(fwd_data), 68'(2));
    chk("fwd_be", 68'(fwd_be), 68'(3));
    ld_addr = 32'h204;
    #1;
    chk("fwd_miss", 68'(fwd_hit), 68'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
